// File: rtl/vga_timing_gen_if.sv
// Video port bundle for vga_timing_gen: pattern controls in, timing, coordinates and colour out.
// The generator side is the master; a pixel sink or DAC wrapper is the slave.
interface vga_timing_gen_if #(
    parameter int COLOR_W = 4,
    parameter int XW      = 10,
    parameter int YW      = 10
);
    logic [1:0]           iMODE;
    logic [3*COLOR_W-1:0] iCOLOR;
    logic                 oHS;
    logic                 oVS;
    logic                 oDE;
    logic [XW-1:0]        oX;
    logic [YW-1:0]        oY;
    logic [COLOR_W-1:0]   oR;
    logic [COLOR_W-1:0]   oG;
    logic [COLOR_W-1:0]   oB;
    logic                 oFRAME_START;

    modport master (
        input  iMODE, iCOLOR,
        output oHS, oVS, oDE, oX, oY, oR, oG, oB, oFRAME_START
    );

    modport slave (
        output iMODE, iCOLOR,
        input  oHS, oVS, oDE, oX, oY, oR, oG, oB, oFRAME_START
    );
endinterface

// File: rtl/vga_timing_gen.sv
// Parametrised VGA timing and test-pattern generator.
// Counters walk the full raster; mode, colour and box position only change on the
// last pixel of a frame so a frame is never torn. Every output is registered one
// cycle behind the counter state it describes, so all outputs stay mutually aligned.
module vga_timing_gen #(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter bit HS_POL   = 1'b0,
    parameter bit VS_POL   = 1'b0,
    parameter int COLOR_W  = 4,
    parameter int CHK_LOG2 = 5,
    parameter int BOX      = 32,
    parameter int STEP     = 2
) (
    input  logic              iVGA_CLK,
    input  logic              iRST,
    vga_timing_gen_if.master  vga
);
    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int XW      = $clog2(H_TOTAL);
    localparam int YW      = $clog2(V_TOTAL);

    typedef logic [XW-1:0] x_t;
    typedef logic [XW:0]   xe_t;   // one spare bit so porch sums never wrap
    typedef logic [YW-1:0] y_t;
    typedef logic [YW:0]   ye_t;

    localparam xe_t H_ACT  = xe_t'(H_ACTIVE);
    localparam xe_t HS_BEG = xe_t'(H_ACTIVE + H_FP);
    localparam xe_t HS_END = xe_t'(H_ACTIVE + H_FP + H_SYNC);
    localparam xe_t H_LAST = xe_t'(H_TOTAL - 1);
    localparam xe_t BAR_W  = xe_t'(H_ACTIVE / 8);
    localparam xe_t BOX_X  = xe_t'(BOX);
    localparam xe_t STEP_X = xe_t'(STEP);
    localparam ye_t V_ACT  = ye_t'(V_ACTIVE);
    localparam ye_t VS_BEG = ye_t'(V_ACTIVE + V_FP);
    localparam ye_t VS_END = ye_t'(V_ACTIVE + V_FP + V_SYNC);
    localparam ye_t V_LAST = ye_t'(V_TOTAL - 1);
    localparam ye_t BOX_Y  = ye_t'(BOX);
    localparam ye_t STEP_Y = ye_t'(STEP);

    x_t                   hcnt;
    y_t                   vcnt;
    logic [1:0]           mode_q;
    logic [3*COLOR_W-1:0] color_q;
    x_t                   box_x;
    y_t                   box_y;

    xe_t hx, bx_far;
    ye_t vy, by_far;
    logic h_last, frame_last;

    assign hx         = {1'b0, hcnt};
    assign vy         = {1'b0, vcnt};
    assign h_last     = (hx == H_LAST);
    assign frame_last = h_last && (vy == V_LAST);
    assign bx_far     = {1'b0, box_x} + BOX_X + STEP_X;
    assign by_far     = {1'b0, box_y} + BOX_Y + STEP_Y;

    // Raster counters: hcnt wraps every line, vcnt advances on that wrap.
    always_ff @(posedge iVGA_CLK or posedge iRST) begin
        if (iRST) begin
            hcnt <= '0;
            vcnt <= '0;
        end else if (h_last) begin
            hcnt <= '0;
            vcnt <= frame_last ? '0 : vcnt + y_t'(1);
        end else begin
            hcnt <= hcnt + x_t'(1);
        end
    end

    // Frame-boundary latch: pattern controls and box position move only here.
    always_ff @(posedge iVGA_CLK or posedge iRST) begin
        if (iRST) begin
            mode_q  <= '0;
            color_q <= '0;
            box_x   <= '0;
            box_y   <= '0;
        end else if (frame_last) begin
            mode_q  <= vga.iMODE;
            color_q <= vga.iCOLOR;
            box_x   <= (bx_far > H_ACT) ? '0 : box_x + x_t'(STEP);
            box_y   <= (by_far > V_ACT) ? '0 : box_y + y_t'(STEP);
        end
    end

    logic                de, hs_on, vs_on, chk_on, in_box;
    xe_t                 bar_q;
    logic [2:0]          bar;
    logic [COLOR_W-1:0]  r, g, b;

    // Pixel decode for the current counter position; blanking forces black.
    always_comb begin
        de     = (hx < H_ACT) && (vy < V_ACT);
        hs_on  = (hx >= HS_BEG) && (hx < HS_END);
        vs_on  = (vy >= VS_BEG) && (vy < VS_END);
        bar_q  = hx / BAR_W;
        bar    = (bar_q > xe_t'(7)) ? 3'd7 : bar_q[2:0];
        chk_on = hcnt[CHK_LOG2] ^ vcnt[CHK_LOG2];
        in_box = (hx >= {1'b0, box_x}) && (hx < {1'b0, box_x} + BOX_X) &&
                 (vy >= {1'b0, box_y}) && (vy < {1'b0, box_y} + BOX_Y);
        r = '0;
        g = '0;
        b = '0;
        if (de) begin
            case (mode_q)
                2'd0: {r, g, b} = color_q;
                2'd1: begin
                    // W,Y,C,G,M,R,B,K: red off on bit1, green off on bit2, blue off on bit0
                    r = {COLOR_W{~bar[1]}};
                    g = {COLOR_W{~bar[2]}};
                    b = {COLOR_W{~bar[0]}};
                end
                2'd2: {r, g, b} = {(3*COLOR_W){chk_on}};
                default: if (in_box) {r, g, b} = color_q;
            endcase
        end
    end

    // Output register stage: one cycle behind the counters, all fields aligned.
    always_ff @(posedge iVGA_CLK or posedge iRST) begin
        if (iRST) begin
            vga.oHS          <= ~HS_POL;
            vga.oVS          <= ~VS_POL;
            vga.oDE          <= 1'b0;
            vga.oX           <= '0;
            vga.oY           <= '0;
            vga.oR           <= '0;
            vga.oG           <= '0;
            vga.oB           <= '0;
            vga.oFRAME_START <= 1'b0;
        end else begin
            vga.oHS          <= hs_on ? HS_POL : ~HS_POL;
            vga.oVS          <= vs_on ? VS_POL : ~VS_POL;
            vga.oDE          <= de;
            vga.oX           <= hcnt;
            vga.oY           <= vcnt;
            vga.oR           <= r;
            vga.oG           <= g;
            vga.oB           <= b;
            vga.oFRAME_START <= (hcnt == '0) && (vcnt == '0);
        end
    end
endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: two small-raster instances (active-low 4-bit, active-high
// 8-bit) run side by side under random mid-frame and on-latch control changes. A
// raster model derived from the elapsed cycle count predicts every output each cycle.
module tb_vga_timing_gen;
    localparam int A_HA = 48, A_HFP = 4, A_HSY = 8, A_HBP = 4;
    localparam int A_VA = 32, A_VFP = 2, A_VSY = 2, A_VBP = 4;
    localparam int A_HT = A_HA + A_HFP + A_HSY + A_HBP;
    localparam int A_VT = A_VA + A_VFP + A_VSY + A_VBP;
    localparam int A_FT = A_HT * A_VT;
    localparam int A_XW = $clog2(A_HT), A_YW = $clog2(A_VT);
    localparam int A_CW = 4, A_CHK = 3, A_BOX = 8, A_STEP = 4;

    localparam int B_HA = 44, B_HFP = 2, B_HSY = 6, B_HBP = 4;
    localparam int B_VA = 20, B_VFP = 1, B_VSY = 3, B_VBP = 2;
    localparam int B_HT = B_HA + B_HFP + B_HSY + B_HBP;
    localparam int B_VT = B_VA + B_VFP + B_VSY + B_VBP;
    localparam int B_FT = B_HT * B_VT;
    localparam int B_XW = $clog2(B_HT), B_YW = $clog2(B_VT);
    localparam int B_CW = 8, B_CHK = 2, B_BOX = 6, B_STEP = 3;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    vga_timing_gen_if #(.COLOR_W(A_CW), .XW(A_XW), .YW(A_YW)) ifa ();
    vga_timing_gen_if #(.COLOR_W(B_CW), .XW(B_XW), .YW(B_YW)) ifb ();

    vga_timing_gen #(
        .H_ACTIVE(A_HA), .H_FP(A_HFP), .H_SYNC(A_HSY), .H_BP(A_HBP),
        .V_ACTIVE(A_VA), .V_FP(A_VFP), .V_SYNC(A_VSY), .V_BP(A_VBP),
        .HS_POL(1'b0), .VS_POL(1'b0), .COLOR_W(A_CW), .CHK_LOG2(A_CHK),
        .BOX(A_BOX), .STEP(A_STEP)
    ) dut_a (.iVGA_CLK(clk), .iRST(rst), .vga(ifa));

    vga_timing_gen #(
        .H_ACTIVE(B_HA), .H_FP(B_HFP), .H_SYNC(B_HSY), .H_BP(B_HBP),
        .V_ACTIVE(B_VA), .V_FP(B_VFP), .V_SYNC(B_VSY), .V_BP(B_VBP),
        .HS_POL(1'b1), .VS_POL(1'b1), .COLOR_W(B_CW), .CHK_LOG2(B_CHK),
        .BOX(B_BOX), .STEP(B_STEP)
    ) dut_b (.iVGA_CLK(clk), .iRST(rst), .vga(ifb));

    typedef struct {
        int ha, hfp, hsy, hbp, va, vfp, vsy, vbp, hpol, vpol, cw, chk, box, step;
    } cfg_t;

    cfg_t ca, cb;
    int n_chk = 0, n_err = 0;
    int n = 0;  // clock edges since reset release
    int          mode_a [64], bx_a [64], by_a [64];
    logic [23:0] col_a  [64];
    int          mode_b [64], bx_b [64], by_b [64];
    logic [23:0] col_b  [64];

    task automatic chk_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic int box_next(int pos, int box, int step, int act);
        return (pos + box + step > act) ? 0 : pos + step;
    endfunction

    // Expected {fs,de,hs,vs,x16,y16,r8,g8,b8} after n edges, given the frame's controls.
    function automatic logic [63:0] model_px(cfg_t c, int nn, int mode, logic [23:0] col,
                                             int bx, int by);
        int ht, vt, p, h, v, idx, mx;
        logic de, hs, vs, fs;
        logic [7:0] r, g, b;
        logic [2:0] bars [8];
        logic [2:0] rgb3;
        if (nn == 0) return {1'b0, 1'b0, (c.hpol == 0), (c.vpol == 0), 56'b0};
        bars = '{3'b111, 3'b110, 3'b011, 3'b010, 3'b101, 3'b100, 3'b001, 3'b000};
        ht = c.ha + c.hfp + c.hsy + c.hbp;
        vt = c.va + c.vfp + c.vsy + c.vbp;
        p  = nn - 1;
        h  = p % ht;
        v  = (p / ht) % vt;
        de = (h < c.ha) && (v < c.va);
        hs = (h >= c.ha + c.hfp && h < c.ha + c.hfp + c.hsy) ? (c.hpol != 0) : (c.hpol == 0);
        vs = (v >= c.va + c.vfp && v < c.va + c.vfp + c.vsy) ? (c.vpol != 0) : (c.vpol == 0);
        fs = (h == 0) && (v == 0);
        mx = (1 << c.cw) - 1;
        r = 8'h0; g = 8'h0; b = 8'h0;
        if (de) begin
            case (mode)
                0: {r, g, b} = col;
                1: begin
                    idx = h / (c.ha / 8);
                    if (idx > 7) idx = 7;
                    rgb3 = bars[idx];
                    r = rgb3[2] ? 8'(mx) : 8'h0;
                    g = rgb3[1] ? 8'(mx) : 8'h0;
                    b = rgb3[0] ? 8'(mx) : 8'h0;
                end
                2: if ((((h >> c.chk) ^ (v >> c.chk)) & 1) == 1) begin
                    r = 8'(mx); g = 8'(mx); b = 8'(mx);
                end
                default: if (h >= bx && h < bx + c.box && v >= by && v < by + c.box)
                    {r, g, b} = col;
            endcase
        end
        return {fs, de, hs, vs, 16'(h), 16'(v), r, g, b};
    endfunction

    function automatic logic [63:0] obs_a();
        return {ifa.oFRAME_START, ifa.oDE, ifa.oHS, ifa.oVS, 16'(ifa.oX), 16'(ifa.oY),
                8'(ifa.oR), 8'(ifa.oG), 8'(ifa.oB)};
    endfunction

    function automatic logic [63:0] obs_b();
        return {ifb.oFRAME_START, ifb.oDE, ifb.oHS, ifb.oVS, 16'(ifb.oX), 16'(ifb.oY),
                ifb.oR, ifb.oG, ifb.oB};
    endfunction

    task automatic check_all(input string when);
        int fa, fb;
        fa = (n == 0) ? 0 : (n - 1) / A_FT;
        fb = (n == 0) ? 0 : (n - 1) / B_FT;
        chk_eq($sformatf("A_%s n=%0d", when, n), obs_a(),
               model_px(ca, n, mode_a[fa], col_a[fa], bx_a[fa], by_a[fa]));
        chk_eq($sformatf("B_%s n=%0d", when, n), obs_b(),
               model_px(cb, n, mode_b[fb], col_b[fb], bx_b[fb], by_b[fb]));
    endtask

    // Random control changes, some landing exactly on the last-pixel cycle;
    // the model records what is present when the frame boundary is crossed.
    task automatic drive_inputs();
        int k;
        if ($urandom_range(0, A_FT / 2) == 0 ||
            (n % A_FT == A_FT - 1 && $urandom_range(0, 1) == 1)) begin
            ifa.iMODE  = 2'($urandom_range(0, 3));
            ifa.iCOLOR = 12'($urandom);
        end
        if ($urandom_range(0, B_FT / 2) == 0 ||
            (n % B_FT == B_FT - 1 && $urandom_range(0, 1) == 1)) begin
            ifb.iMODE  = 2'($urandom_range(0, 3));
            ifb.iCOLOR = 24'($urandom);
        end
        if (n % A_FT == A_FT - 1) begin
            k = n / A_FT + 1;
            mode_a[k] = int'(ifa.iMODE);
            col_a[k]  = {4'h0, ifa.iCOLOR[11:8], 4'h0, ifa.iCOLOR[7:4], 4'h0, ifa.iCOLOR[3:0]};
            bx_a[k]   = box_next(bx_a[k-1], A_BOX, A_STEP, A_HA);
            by_a[k]   = box_next(by_a[k-1], A_BOX, A_STEP, A_VA);
        end
        if (n % B_FT == B_FT - 1) begin
            k = n / B_FT + 1;
            mode_b[k] = int'(ifb.iMODE);
            col_b[k]  = ifb.iCOLOR;
            bx_b[k]   = box_next(bx_b[k-1], B_BOX, B_STEP, B_HA);
            by_b[k]   = box_next(by_b[k-1], B_BOX, B_STEP, B_VA);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        n++;
        @(negedge clk);
        check_all("px");
        drive_inputs();
    endtask

    task automatic reset_model();
        n = 0;
        mode_a[0] = 0; col_a[0] = 24'h0; bx_a[0] = 0; by_a[0] = 0;
        mode_b[0] = 0; col_b[0] = 24'h0; bx_b[0] = 0; by_b[0] = 0;
    endtask

    initial begin
        ca = '{ha:A_HA, hfp:A_HFP, hsy:A_HSY, hbp:A_HBP, va:A_VA, vfp:A_VFP, vsy:A_VSY,
               vbp:A_VBP, hpol:0, vpol:0, cw:A_CW, chk:A_CHK, box:A_BOX, step:A_STEP};
        cb = '{ha:B_HA, hfp:B_HFP, hsy:B_HSY, hbp:B_HBP, va:B_VA, vfp:B_VFP, vsy:B_VSY,
               vbp:B_VBP, hpol:1, vpol:1, cw:B_CW, chk:B_CHK, box:B_BOX, step:B_STEP};
        ifa.iMODE = 2'd1; ifa.iCOLOR = 12'hABC;
        ifb.iMODE = 2'd2; ifb.iCOLOR = 24'h123456;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset_model();
        check_all("rst");
        rst = 1'b0;

        // first frames start black, then follow the random controls
        repeat (3 * A_FT) tick();

        // walk to line 10, pixel 30 of A and hit reset between clock edges
        for (int i = 0; i < A_FT && (n % A_FT) != (10 * A_HT + 30); i++) tick();
        #2 rst = 1'b1;
        #1 reset_model();
        check_all("async");
        @(posedge clk);
        @(negedge clk);
        check_all("held");
        rst = 1'b0;

        // long run covers box wrap on both axes for both instances
        repeat (12 * A_FT) tick();

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule
